// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver (5..9 data bits, optional parity, 1/2 stop bits).
// Latency: word visible 1 clk after the last stop-bit decision point.
// Backpressure: rx_valid held until rx_ready; a new word overwrites an unaccepted one and pulses rx_overrun.
// Option: define UART_RX_MAJORITY_EN for 3-sample majority voting around each sample point.
module uart_rx_frame #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int S        = BIT_CLKS / 2;
  localparam int CW       = $clog2(BIT_CLKS);
`ifdef UART_RX_MAJORITY_EN
  localparam int DECIDE   = S + 1;   // vote needs the sample after S
`else
  localparam int DECIDE   = S;
`endif
  localparam logic [CW-1:0] CNT_LAST   = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] CNT_DECIDE = CW'(DECIDE);
  localparam logic [3:0]    LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

  state_t                 state, state_nxt;
  logic                   sync1, rx_s, rx_prev;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_err_q;
  logic                   frame_acc;
  logic                   tick;
  logic                   samp_bit;
  logic                   commit;

`ifdef UART_RX_MAJORITY_EN
  logic h1, h2;

  // History of rx_s so the vote sees cnt==S-1, S, S+1 at the decision cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      h1 <= 1'b1;
      h2 <= 1'b1;
    end else begin
      h1 <= rx_s;
      h2 <= h1;
    end
  end

  assign samp_bit = (rx_s & h1) | (rx_s & h2) | (h1 & h2);
`else
  assign samp_bit = rx_s;
`endif

  assign tick    = (cnt == CNT_DECIDE);
  assign rx_busy = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; commit marks the decision on the final stop bit
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE:  if (rx_prev && !rx_s) state_nxt = START;
      START: if (tick) state_nxt = samp_bit ? IDLE : DATA;
      DATA:  if (tick && (bit_idx == LAST_DATA)) state_nxt = (PARITY != 0) ? PAR : STOP;
      PAR:   if (tick) state_nxt = STOP;
      STOP:  if (tick && (stop_idx == LAST_STOP)) begin
               commit    = 1'b1;
               state_nxt = samp_bit ? IDLE : BRK;   // held-low line must rise before re-arming
             end
      BRK:   if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Synchroniser, bit timing and per-frame accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_err_q <= 1'b0;
      frame_acc <= 1'b0;
    end else begin
      sync1   <= rx_line;
      rx_s    <= sync1;
      rx_prev <= rx_s;
      // cnt runs freely across bits so each decision lands one bit period after the last
      if (state == IDLE || state == BRK) cnt <= '0;
      else if (cnt == CNT_LAST)          cnt <= '0;
      else                               cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          bit_idx   <= '0;
          stop_idx  <= 1'b0;
          par_err_q <= 1'b0;
          frame_acc <= 1'b0;
        end
        DATA: if (tick) begin
          shreg   <= {samp_bit, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 4'd1;
        end
        PAR: if (tick) par_err_q <= (((^shreg) ^ samp_bit) != (PARITY == 2));
        STOP: if (tick) begin
          stop_idx <= stop_idx + 1'b1;
          if (!samp_bit) frame_acc <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output word register and valid/ready handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= commit & rx_valid & ~rx_ready;
      if (commit) begin
        rx_data       <= shreg;
        rx_parity_err <= par_err_q;
        rx_frame_err  <= frame_acc | ~samp_bit;
        rx_valid      <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 instance (a) and an 8E1 instance (b), BIT_CLKS=10, S=5.
module tb_uart_rx_frame;

  localparam int BC = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       line_a, line_b, rdy_a, rdy_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;
  logic       ovr_a_sig, ovr_b_sig, busy_a, busy_b;

  always #5 clk = ~clk;

  uart_rx_frame #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .rx_line(line_a), .rx_data(data_a), .rx_valid(valid_a), .rx_ready(rdy_a),
    .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_overrun(ovr_a_sig), .rx_busy(busy_a));

  uart_rx_frame #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_par (
    .clk(clk), .rst(rst), .rx_line(line_b), .rx_data(data_b), .rx_valid(valid_b), .rx_ready(rdy_b),
    .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_overrun(ovr_b_sig), .rx_busy(busy_b));

  typedef struct {
    logic       sel;       // 0: 8N1 instance, 1: even-parity instance
    logic [7:0] data;
    logic       pbit;      // parity bit driven (parity instance only)
    logic       stop;      // stop bit level driven
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  int n_checks = 0;
  int n_pass   = 0;
  int ovr_a    = 0;
  int ovr_b    = 0;
  int got_n;
  int n;
  logic [9:0] w;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];

  // Record every accepted word {perr, ferr, data}; inputs only change on negedge
  always @(negedge clk) begin
    #1;
    if (valid_a && rdy_a) q_a.push_back({perr_a, ferr_a, data_a});
    if (valid_b && rdy_b) q_b.push_back({perr_b, ferr_b, data_b});
    if (ovr_a_sig) ovr_a++;
    if (ovr_b_sig) ovr_b++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic hold(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic set_line(input logic sel, input logic v);
    if (sel) line_b = v;
    else     line_a = v;
  endtask

  task automatic drive_bit(input logic sel, input logic v);
    @(negedge clk);
    set_line(sel, v);
    repeat (BC - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic sel, input logic [7:0] d, input logic has_par,
                            input logic pbit, input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (has_par) drive_bit(sel, pbit);
    drive_bit(sel, stop);
    drive_bit(sel, 1'b1);
  endtask

  task automatic pop_word(input logic sel);
    w = 'x;
    if (sel) begin
      got_n = q_b.size();
      if (got_n > 0) w = q_b.pop_front();
    end else begin
      got_n = q_a.size();
      if (got_n > 0) w = q_a.pop_front();
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};

    rst = 1'b1; line_a = 1'b1; line_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    hold(3);
    check("reset valid", valid_a, 0);
    check("reset busy", busy_a, 0);
    check("reset data", data_a, 0);
    check("reset perr", perr_a, 0);
    check("reset ferr", ferr_a, 0);
    check("reset overrun", ovr_a_sig, 0);
    check("reset valid b", valid_b, 0);
    @(negedge clk); rst = 1'b0;
    hold(5);

    // Table-driven frames
    ovr_a = 0; ovr_b = 0;
    for (int i = 0; i < NV; i++) begin
      q_a.delete(); q_b.delete();
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].sel, vecs[i].pbit, vecs[i].stop);
      hold(5);
      pop_word(vecs[i].sel);
      check($sformatf("vec%0d count", i), got_n, 1);
      check($sformatf("vec%0d data", i), w[7:0], vecs[i].exp_data);
      check($sformatf("vec%0d perr", i), w[9], vecs[i].exp_perr);
      check($sformatf("vec%0d ferr", i), w[8], vecs[i].exp_ferr);
    end
    check("no overrun a", ovr_a, 0);
    check("no overrun b", ovr_b, 0);

    // 3-clk low glitch on idle line
    q_a.delete();
    @(negedge clk); line_a = 1'b0;
    repeat (3) @(negedge clk);
    line_a = 1'b1;
    check("glitch busy", busy_a, 1);
    n = 0;
    while (busy_a && n < BC) begin
      @(negedge clk);
      n++;
    end
    check("glitch busy drops", busy_a, 0);
    hold(2 * BC);
    check("glitch no word", q_a.size(), 0);

    // Break: stop bit low, line held low 30 bit times
    q_a.delete();
    for (int i = 0; i < 10; i++) drive_bit(1'b0, 1'b0);
    hold(20 * BC);
    check("break busy", busy_a, 1);
    @(negedge clk); line_a = 1'b1;
    hold(2 * BC);
    check("break idle", busy_a, 0);
    pop_word(1'b0);
    check("break count", got_n, 1);
    check("break data", w[7:0], 8'h00);
    check("break ferr", w[8], 1);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    hold(5);
    pop_word(1'b0);
    check("post-break count", got_n, 1);
    check("post-break data", w[7:0], 8'h5A);
    check("post-break ferr", w[8], 0);

    // Overrun with consumer stalled
    q_a.delete(); ovr_a = 0;
    @(negedge clk); rdy_a = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    hold(5);
    check("ovr first valid", valid_a, 1);
    check("ovr first data", data_a, 8'h11);
    check("ovr first pulse", ovr_a, 0);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    hold(5);
    check("ovr pulse count", ovr_a, 1);
    check("ovr valid held", valid_a, 1);
    check("ovr data", data_a, 8'h22);
    check("ovr none accepted", q_a.size(), 0);
    @(negedge clk); rdy_a = 1'b1;
    hold(2);
    check("ovr valid cleared", valid_a, 0);
    pop_word(1'b0);
    check("ovr accept count", got_n, 1);
    check("ovr accept data", w[7:0], 8'h22);
    check("ovr data holds", data_a, 8'h22);

    // Reset in the middle of a data field
    q_a.delete();
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1);
    check("mid-frame busy", busy_a, 1);
    @(negedge clk); rst = 1'b1; line_a = 1'b1;
    hold(2);
    check("mid rst valid", valid_a, 0);
    check("mid rst busy", busy_a, 0);
    check("mid rst data", data_a, 0);
    check("mid rst ferr", ferr_a, 0);
    @(negedge clk); rst = 1'b0;
    hold(3 * BC);
    check("mid rst no word", q_a.size(), 0);
    check("mid rst idle", busy_a, 0);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    hold(5);
    pop_word(1'b0);
    check("post-rst count", got_n, 1);
    check("post-rst data", w[7:0], 8'h3C);

`ifdef UART_RX_MAJORITY_EN
    // 1-clk high glitch landing on the sample point of data bit 2 of 0x00
    q_a.delete();
    for (int k = 0; k < 11 * BC; k++) begin
      @(negedge clk);
      line_a = (k == 3 * BC + 6) ? 1'b1 : (k >= 9 * BC);
    end
    hold(5);
    pop_word(1'b0);
    check("majority count", got_n, 1);
    check("majority data", w[7:0], 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
